// File: rtl/ddr3_test_pkg.sv
// ddr3_test_pkg: shared constants for the DDR3 loopback traffic checker.
//   - controller main_state codes that accept a write word / read request
//   - checker FSM state encoding
//   - LFSR seed and feedback tap mask (taps 16,14,13,11, right-shift form)
package ddr3_test_pkg;

  localparam int unsigned CTRL_STATE_WRITE_DATA = 8;
  localparam int unsigned CTRL_STATE_READ_DATA  = 11;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WRITE  = 2'd1;
  localparam logic [1:0] ST_READ   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

  localparam logic [15:0] LFSR_SEED     = 16'hACE1;
  // Bits 0,2,3,5 of a right-shifting register correspond to taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAP_MASK = 16'h002D;

endpackage

// File: rtl/ddr3_pattern_gen.sv
// ddr3_pattern_gen: test data pattern source, one word per step.
//   clk_i, reset_i : clock, synchronous active-high reset (value -> 0)
//   load_i         : load the first pattern word (has priority over step_i)
//   step_i         : advance to the next pattern word
//   value_o        : current pattern word
// Macro LOOPBACK_LFSR_PATTERN_EN selects the Fibonacci LFSR sequence seeded
// with LFSR_SEED; otherwise the sequence is 1, 2, 3, ... (word i = i + 1).
module ddr3_pattern_gen
  import ddr3_test_pkg::*;
#(
  parameter int unsigned DQ_BITWIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   load_i,
  input  logic                   step_i,
  output logic [DQ_BITWIDTH-1:0] value_o
);

  logic [DQ_BITWIDTH-1:0] value_q, value_d;
  logic [DQ_BITWIDTH-1:0] first_w, next_w;

`ifdef LOOPBACK_LFSR_PATTERN_EN
  localparam logic [DQ_BITWIDTH-1:0] TAPS = DQ_BITWIDTH'(LFSR_TAP_MASK);
  assign first_w = DQ_BITWIDTH'(LFSR_SEED);
  assign next_w  = {^(value_q & TAPS), value_q[DQ_BITWIDTH-1:1]};
`else
  assign first_w = DQ_BITWIDTH'(1);
  assign next_w  = value_q + DQ_BITWIDTH'(1);
`endif

  always_comb begin
    value_d = value_q;
    if (load_i)      value_d = first_w;
    else if (step_i) value_d = next_w;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) value_q <= '0;
    else         value_q <= value_d;
  end

  assign value_o = value_q;

endmodule

// File: rtl/ddr3_loopback_traffic_checker.sv
// ddr3_loopback_traffic_checker: writes NUM_OF_TEST_DATA pattern words to
// addresses 0.., reads them back through the controller and checks them.
//   clk, reset                     : clock, synchronous active-high reset
//   start                          : pulse, begins a run (ignored while busy)
//   main_state                     : controller FSM state (accept qualifiers)
//   data_from_ram(_valid)          : returned read data, in issue order
//   write_enable, read_enable      : requests to the controller
//   i_user_data_address            : request address (zero-extended index)
//   data_to_ram                    : write data
//   busy, done, pass, timed_out    : run status (pass/timed_out valid at done)
//   error_count                    : saturating mismatch count
//   first_error_address            : address of first mismatch, 0 if none
// Macro LOOPBACK_LFSR_PATTERN_EN (inside ddr3_pattern_gen) selects LFSR data.
module ddr3_loopback_traffic_checker
  import ddr3_test_pkg::*;
#(
  parameter int unsigned DQ_BITWIDTH           = 16,
  parameter int unsigned ADDRESS_BITWIDTH      = 14,
  parameter int unsigned BANK_ADDRESS_BITWIDTH = 3,
  parameter int unsigned NUM_OF_TEST_DATA      = 4,
  parameter int unsigned STATE_BITWIDTH        = 5,
  parameter int unsigned STATE_WRITE_DATA      = CTRL_STATE_WRITE_DATA,
  parameter int unsigned STATE_READ_DATA       = CTRL_STATE_READ_DATA,
  parameter int unsigned TIMEOUT_CYCLES        = 65535
) (
  input  logic                                              clk,
  input  logic                                              reset,
  input  logic                                              start,
  input  logic [STATE_BITWIDTH-1:0]                         main_state,
  input  logic [DQ_BITWIDTH-1:0]                            data_from_ram,
  input  logic                                              data_from_ram_valid,
  output logic                                              write_enable,
  output logic                                              read_enable,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] i_user_data_address,
  output logic [DQ_BITWIDTH-1:0]                            data_to_ram,
  output logic                                              busy,
  output logic                                              done,
  output logic                                              pass,
  output logic                                              timed_out,
  output logic [$clog2(NUM_OF_TEST_DATA+1)-1:0]             error_count,
  output logic [BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH-1:0] first_error_address
);

  localparam int unsigned AW = BANK_ADDRESS_BITWIDTH + ADDRESS_BITWIDTH;
  localparam int unsigned CW = $clog2(NUM_OF_TEST_DATA + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST    = CW'(NUM_OF_TEST_DATA - 1);
  localparam logic [CW-1:0] ALL     = CW'(NUM_OF_TEST_DATA);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [STATE_BITWIDTH-1:0] WR_CODE = STATE_BITWIDTH'(STATE_WRITE_DATA);
  localparam logic [STATE_BITWIDTH-1:0] RD_CODE = STATE_BITWIDTH'(STATE_READ_DATA);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, ret_cnt_q, ret_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          we_q, we_d, re_q, re_d, busy_q, busy_d, done_q, done_d;
  logic          pass_q, pass_d, to_q, to_d;
  logic [CW-1:0] err_q, err_d;
  logic [AW-1:0] ferr_q, ferr_d;

  logic [DQ_BITWIDTH-1:0] wr_val, ck_val;
  logic wr_load, wr_step, ck_load, ck_step, finish;
  logic accept, issue, ret, mismatch;

  ddr3_pattern_gen #(.DQ_BITWIDTH(DQ_BITWIDTH)) u_writer (
    .clk_i(clk), .reset_i(reset), .load_i(wr_load), .step_i(wr_step), .value_o(wr_val)
  );

  ddr3_pattern_gen #(.DQ_BITWIDTH(DQ_BITWIDTH)) u_checker (
    .clk_i(clk), .reset_i(reset), .load_i(ck_load), .step_i(ck_step), .value_o(ck_val)
  );

  assign accept   = we_q && (main_state == WR_CODE);
  assign issue    = re_q && (main_state == RD_CODE);
  // Returns are counted independently of issues; extras beyond ALL are dropped.
  assign ret      = data_from_ram_valid && (state_q == ST_READ) && (ret_cnt_q != ALL);
  assign mismatch = ret && (data_from_ram != ck_val);

  always_comb begin
    state_d   = state_q;
    wr_cnt_d  = wr_cnt_q;
    rd_cnt_d  = rd_cnt_q;
    ret_cnt_d = ret_cnt_q;
    tmo_d     = tmo_q;
    we_d      = we_q;
    re_d      = re_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    to_d      = to_q;
    err_d     = err_q;
    ferr_d    = ferr_q;
    wr_load   = 1'b0;
    wr_step   = 1'b0;
    ck_load   = 1'b0;
    ck_step   = 1'b0;
    finish    = 1'b0;

    case (state_q)
      ST_IDLE, ST_FINISH: begin
        if (start) begin
          state_d   = ST_WRITE;
          wr_cnt_d  = '0;
          rd_cnt_d  = '0;
          ret_cnt_d = '0;
          tmo_d     = '0;
          we_d      = 1'b1;
          re_d      = 1'b0;
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          to_d      = 1'b0;
          err_d     = '0;
          ferr_d    = '0;
          wr_load   = 1'b1;
          ck_load   = 1'b1;
        end
      end
      ST_WRITE: begin
        if (accept) begin
          wr_step = 1'b1;
          if (wr_cnt_q == LAST) begin
            state_d  = ST_READ;
            we_d     = 1'b0;
            re_d     = 1'b1;
            rd_cnt_d = '0;
          end else begin
            wr_cnt_d = wr_cnt_q + CW'(1);
          end
        end
      end
      ST_READ: begin
        if (issue) begin
          rd_cnt_d = rd_cnt_q + CW'(1);
          if (rd_cnt_q == LAST) re_d = 1'b0;
        end
        if (ret) begin
          ck_step   = 1'b1;
          ret_cnt_d = ret_cnt_q + CW'(1);
          if (mismatch) begin
            if (err_q == '0) ferr_d = AW'(ret_cnt_q);
            if (err_q != '1) err_d = err_q + CW'(1);
          end
          if (ret_cnt_q == LAST) finish = 1'b1;
        end
      end
      default: ;
    endcase

    // busy_q marks WRITE/READ, the only states the watchdog covers.
    if (busy_q) begin
      if (accept || issue || ret) begin
        tmo_d = '0;
      end else if (tmo_q == TMO_MAX) begin
        to_d   = 1'b1;
        finish = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end

    if (finish) begin
      state_d = ST_FINISH;
      we_d    = 1'b0;
      re_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b1;
      pass_d  = (err_d == '0) && !to_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      ret_cnt_q <= '0;
      tmo_q     <= '0;
      we_q      <= 1'b0;
      re_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      to_q      <= 1'b0;
      err_q     <= '0;
      ferr_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      ret_cnt_q <= ret_cnt_d;
      tmo_q     <= tmo_d;
      we_q      <= we_d;
      re_q      <= re_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      to_q      <= to_d;
      err_q     <= err_d;
      ferr_q    <= ferr_d;
    end
  end

  assign write_enable        = we_q;
  assign read_enable         = re_q;
  assign i_user_data_address = (state_q == ST_READ)  ? AW'(rd_cnt_q) :
                               (state_q == ST_WRITE) ? AW'(wr_cnt_q) : '0;
  assign data_to_ram         = we_q ? wr_val : '0;
  assign busy                = busy_q;
  assign done                = done_q;
  assign pass                = pass_q;
  assign timed_out           = to_q;
  assign error_count         = err_q;
  assign first_error_address = ferr_q;

endmodule

// File: tb/tb_ddr3_loopback_traffic_checker.sv
// Bench for ddr3_loopback_traffic_checker: a controller/memory model that
// alternates main_state between the write and read codes, echoes written data
// with a 2-cycle read latency (optionally corrupting address 2 or stalling),
// and a transaction-level scoreboard checked every cycle in tick().
module tb_ddr3_loopback_traffic_checker;

  localparam int DQ  = 16;
  localparam int A   = 14;
  localparam int BA  = 3;
  localparam int N   = 4;
  localparam int SW  = 5;
  localparam int TMO = 100;
  localparam int AW  = BA + A;
  localparam int EW  = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          reset, start;
  logic [SW-1:0] main_state;
  logic [DQ-1:0] data_from_ram;
  logic          data_from_ram_valid;
  logic          write_enable, read_enable, busy, done, pass, timed_out;
  logic [AW-1:0] i_user_data_address, first_error_address;
  logic [DQ-1:0] data_to_ram;
  logic [EW-1:0] error_count;

  ddr3_loopback_traffic_checker #(
    .DQ_BITWIDTH(DQ), .ADDRESS_BITWIDTH(A), .BANK_ADDRESS_BITWIDTH(BA),
    .NUM_OF_TEST_DATA(N), .STATE_BITWIDTH(SW), .STATE_WRITE_DATA(8),
    .STATE_READ_DATA(11), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .main_state(main_state),
    .data_from_ram(data_from_ram), .data_from_ram_valid(data_from_ram_valid),
    .write_enable(write_enable), .read_enable(read_enable),
    .i_user_data_address(i_user_data_address), .data_to_ram(data_to_ram),
    .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
    .error_count(error_count), .first_error_address(first_error_address)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: mode 0 echo, 1 corrupt address 2, 2 stalled controller.
  int            cyc, mode, m_w, m_r, m_ret, m_err;
  logic [AW-1:0] m_first;
  logic [DQ-1:0] mem [N];
  logic          ph;
  int            q_due[$];
  int            q_addr[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Word i of the test pattern.
  function automatic logic [DQ-1:0] pat(input int i);
    logic [DQ-1:0] v;
`ifdef LOOPBACK_LFSR_PATTERN_EN
    v = 16'hACE1;
    for (int k = 0; k < i; k++) v = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
`else
    v = DQ'(i + 1);
`endif
    return v;
  endfunction

  task automatic model_clear();
    m_w = 0; m_r = 0; m_ret = 0; m_err = 0; m_first = '0;
    q_due.delete(); q_addr.delete();
  endtask

  // One cycle: drive inputs for the next edge and score what the DUT does there.
  task automatic tick();
    logic [DQ-1:0] d;
    int a;
    @(negedge clk);
    cyc++;
    start = 1'b0;
    data_from_ram_valid = 1'b0;
    data_from_ram = '0;
    if (q_due.size() > 0 && q_due[0] == cyc) begin
      void'(q_due.pop_front());
      a = q_addr.pop_front();
      d = (a < N) ? mem[a] : '0;
      if (mode == 1 && a == 2) d = d ^ 16'h0004;
      data_from_ram_valid = 1'b1;
      data_from_ram = d;
      if (m_ret < N) begin
        if (d !== pat(m_ret)) begin
          if (m_err == 0) m_first = AW'(m_ret);
          m_err++;
        end
        m_ret++;
      end
    end
    ph = ~ph;
    main_state = (mode == 2) ? '0 : (ph ? SW'(8) : SW'(11));
    if (write_enable && main_state == SW'(8)) begin
      chk("wr_addr", 64'(i_user_data_address), 64'(m_w));
      chk("wr_data", 64'(data_to_ram), 64'(pat(m_w)));
      if (i_user_data_address < N) mem[i_user_data_address] = data_to_ram;
      m_w++;
    end
    if (read_enable && main_state == SW'(11)) begin
      chk("rd_addr", 64'(i_user_data_address), 64'(m_r));
      q_due.push_back(cyc + 2);
      q_addr.push_back(int'(i_user_data_address));
      m_r++;
    end
    chk("status_consistency",
        64'({write_enable && read_enable, done && busy, (write_enable || read_enable) && !busy}),
        64'(0));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_we"},   64'(write_enable), 0);
    chk({tag, "_re"},   64'(read_enable), 0);
    chk({tag, "_addr"}, 64'(i_user_data_address), 0);
    chk({tag, "_data"}, 64'(data_to_ram), 0);
    chk({tag, "_busy"}, 64'(busy), 0);
    chk({tag, "_done"}, 64'(done), 0);
    chk({tag, "_pass"}, 64'(pass), 0);
    chk({tag, "_to"},   64'(timed_out), 0);
    chk({tag, "_errc"}, 64'(error_count), 0);
    chk({tag, "_ferr"}, 64'(first_error_address), 0);
  endtask

  // Full run; extra_start pulses start again while busy. n = cycles to done.
  task automatic do_run(input string tag, input int md, input bit exp_to,
                        input bit extra_start, output int n);
    mode = md;
    model_clear();
    start = 1'b1;
    tick();
    chk({tag, "_busy_at_start"}, 64'(busy), 1);
    chk({tag, "_done_cleared"},  64'(done), 0);
    chk({tag, "_errc_cleared"},  64'(error_count), 0);
    chk({tag, "_ferr_cleared"},  64'(first_error_address), 0);
    n = 0;
    while (!done && n < 400) begin
      if (extra_start && n == 3) start = 1'b1;
      tick();
      n++;
    end
    chk({tag, "_done"},      64'(done), 1);
    chk({tag, "_busy_end"},  64'(busy), 0);
    chk({tag, "_to"},        64'(timed_out), 64'(exp_to));
    chk({tag, "_pass"},      64'(pass), 64'((m_err == 0) && !exp_to));
    chk({tag, "_errc"},      64'(error_count), 64'(m_err));
    chk({tag, "_ferr"},      64'(first_error_address), 64'(m_first));
    chk({tag, "_we_end"},    64'(write_enable), 0);
    chk({tag, "_re_end"},    64'(read_enable), 0);
    if (!exp_to) begin
      chk({tag, "_writes"},  64'(m_w), 64'(N));
      chk({tag, "_reads"},   64'(m_r), 64'(N));
      chk({tag, "_returns"}, 64'(m_ret), 64'(N));
    end
  endtask

  initial begin
    int n;
    cyc = 0; mode = 0; ph = 1'b0;
    model_clear();
    reset = 1'b1; start = 1'b0; main_state = '0;
    data_from_ram = '0; data_from_ram_valid = 1'b0;
    tick(); tick();
    check_zero("reset");
    reset = 1'b0;
    tick();

    // Clean echo.
    do_run("echo", 0, 1'b0, 1'b0, n);
    chk("echo_pass_lit", 64'(pass), 1);
    chk("echo_errc_lit", 64'(error_count), 0);
`ifdef LOOPBACK_LFSR_PATTERN_EN
    chk("lfsr_word0", 64'(mem[0]), 64'h0000_0000_0000_ACE1);
    chk("lfsr_word1", 64'(mem[1]), 64'h0000_0000_0000_5670);
    chk("lfsr_word2", 64'(mem[2]), 64'h0000_0000_0000_AB38);
`else
    chk("mem0", 64'(mem[0]), 1);
    chk("mem1", 64'(mem[1]), 2);
    chk("mem2", 64'(mem[2]), 3);
    chk("mem3", 64'(mem[3]), 4);
`endif

    // Corrupted return at address 2.
    do_run("corrupt", 1, 1'b0, 1'b0, n);
    chk("corrupt_pass_lit", 64'(pass), 0);
    chk("corrupt_errc_lit", 64'(error_count), 1);
    chk("corrupt_ferr_lit", 64'(first_error_address), 2);

    // Back-to-back from FINISH, with a start pulse while busy.
    do_run("b2b", 0, 1'b0, 1'b1, n);

    // Stalled controller: timeout after TMO idle cycles.
    do_run("stall", 2, 1'b1, 1'b0, n);
    chk("stall_latency", 64'((n >= TMO) && (n <= TMO + 1)), 1);

    // Reset during the second write beat.
    mode = 0;
    model_clear();
    start = 1'b1;
    tick();
    n = 0;
    while (!(write_enable && i_user_data_address == AW'(1)) && n < 20) begin
      tick();
      n++;
    end
    chk("midrun_second_beat_seen", 64'(write_enable && i_user_data_address == AW'(1)), 1);
    reset = 1'b1;
    tick();
    check_zero("midrun_reset");
    reset = 1'b0;
    model_clear();
    tick();
    do_run("after_reset", 0, 1'b0, 1'b0, n);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr3_loopback_traffic_checker.md
Name: ddr3_loopback_traffic_checker

Overview:
User-side traffic generator and data checker sitting directly upstream/downstream of ddr3_memory_controller. It issues NUM_OF_TEST_DATA sequential writes of a known pattern, reads the same addresses back and compares every returned word. It reports pass/fail, error count and first failing address, and drives the board-level done indication. It replaces ad-hoc loopback logic in the test top.

Parameters:
DQ_BITWIDTH, 16, data word width
ADDRESS_BITWIDTH, 14, row/column address width
BANK_ADDRESS_BITWIDTH, 3, bank address width
NUM_OF_TEST_DATA, 4, words written then read (>=1)
STATE_BITWIDTH, 5, width of controller main_state
STATE_WRITE_DATA, 8, controller state code that accepts one write word
STATE_READ_DATA, 11, controller state code that accepts one read request
TIMEOUT_CYCLES, 65535, cycles without progress before abort

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a loopback run
main_state  in  STATE_BITWIDTH  controller FSM state
data_from_ram  in  DQ_BITWIDTH  read data from controller
data_from_ram_valid  in  1  one-cycle qualifier for data_from_ram
write_enable  out  1  write request to controller
read_enable  out  1  read request to controller
i_user_data_address  out  BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH  request address
data_to_ram  out  DQ_BITWIDTH  write data
busy  out  1  run in progress
done  out  1  run finished; held until next start
pass  out  1  valid when done: no mismatch, no timeout
timed_out  out  1  valid when done
error_count  out  $clog2(NUM_OF_TEST_DATA+1)  mismatches, saturating
first_error_address  out  BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH  address of first mismatch, 0 if none

Behaviour:
- One clock (clk); reset synchronous, active-high. Reset values: all outputs 0, FSM IDLE, counters 0. Reset mid-run aborts immediately; outputs reach reset values on that edge.
- FSM: IDLE -> WRITE on start. WRITE -> READ after NUM_OF_TEST_DATA write beats. READ -> FINISH after NUM_OF_TEST_DATA valid returns. FINISH -> WRITE on start. Any state other than IDLE/FINISH -> FINISH on timeout.
- start while busy is ignored.
- On entering WRITE, the outputs are set registered, so they are visible one cycle after start:
  - done = 0, error_count = 0, pass = 0, timed_out = 0, first_error_address = 0, write index = 0.
- WRITE:
  - write_enable = 1, i_user_data_address = index, data_to_ram = pattern(index).
  - A beat is accepted on any cycle with write_enable && main_state == STATE_WRITE_DATA. Address and data advance on the next edge.
  - The last accept deasserts write_enable on the same edge and asserts read_enable with address 0.
- READ:
  - read_enable = 1. A request is issued on any cycle with read_enable && main_state == STATE_READ_DATA. The issue index increments.
  - After NUM_OF_TEST_DATA issues, read_enable = 0.
  - Returns are compared in order against pattern(return index), independent of the issue counter, and may overlap issues.
  - A mismatch increments error_count (saturating at all-ones). The first mismatch captures its address.
  - data_from_ram_valid outside READ, or beyond NUM_OF_TEST_DATA returns, is ignored.
- FINISH:
  - busy = 0, done = 1, write_enable = 0, read_enable = 0.
  - pass = (error_count == 0) && !timed_out.
- Timeout counter: cleared on every accept/issue/return and on start. When it reaches TIMEOUT_CYCLES, timed_out = 1 -> FINISH.
- busy = 1 in WRITE and READ.
- Address arithmetic: zero-extended index, no wrap (NUM_OF_TEST_DATA <= 2^(BANK_ADDRESS_BITWIDTH+ADDRESS_BITWIDTH)).

Optional Feature:
LOOPBACK_LFSR_PATTERN_EN
- Defined: pattern is a DQ_BITWIDTH Fibonacci LFSR (16-bit taps 16,14,13,11), seed 16'hACE1, one step per word. The checker runs an identical LFSR stepped per return.
- Undefined: pattern(index) = index + 1, truncated to DQ_BITWIDTH, so no word is all-zero.

Decomposition:
- Package ddr3_test_pkg: STATE_WRITE_DATA/STATE_READ_DATA codes, checker FSM state encoding, LFSR seed/taps constants.
- Sub-module ddr3_pattern_gen (load, step, value; feature macro inside), instantiated twice: writer and checker.

Test Plan:
1. Correct echo: model controller cycling 8/11 with 2-cycle read latency, echoing written data; start -> 4 writes to addresses 0..3 with data 1..4, 4 reads, done=1, pass=1, error_count=0.
2. Single corrupted word: model corrupts return of address 2 (data 3 -> 7) -> done=1, pass=0, error_count=1, first_error_address=2.
3. Stalled controller: main_state stuck at 0 after start, TIMEOUT_CYCLES=100 -> done=1 and timed_out=1 within 101 cycles of the last progress, pass=0.
4. Reset mid-run: assert reset during the second write beat -> next edge all outputs 0. Then a fresh start completes with pass=1.
5. Run control: start pulse while busy -> ignored, sequence unchanged. Back-to-back run: start in FINISH clears done/error_count and repeats with identical addresses.
6. LOOPBACK_LFSR_PATTERN_EN defined -> first write word 16'hACE1, following words the LFSR sequence; echo model -> pass=1.
